// File: rtl/sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package sweep_pkg;
  localparam int N_IN_DEF       = 4;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  function automatic int vec_cnt(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/sweep_vec_gen.sv
// Maps the step counter to the applied input vector.
// SWEEP_GRAY_EN selects Gray order (one input toggles per step); default is binary.
module sweep_vec_gen #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] step,
  output logic [N_IN-1:0] vec
);
`ifdef SWEEP_GRAY_EN
  assign vec = step ^ (step >> 1);
`else
  assign vec = step;
`endif
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive vector sequencer that builds truth tables for two implementations
// of one function and flags disagreements. Optional Gray ordering: SWEEP_GRAY_EN.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter  int N_IN       = N_IN_DEF,
  parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
  localparam int VEC_CNT    = vec_cnt(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [N_IN-1:0]    vec_o,
  input  logic               fa_i,
  input  logic               fb_i,
  output logic               busy,
  output logic               done,
  output logic [VEC_CNT-1:0] tt_a,
  output logic [VEC_CNT-1:0] tt_b,
  output logic               mismatch,
  output logic [N_IN-1:0]    first_bad_idx,
  output logic [N_IN:0]      err_cnt
);
  localparam int            CW         = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYC);
  localparam logic [N_IN:0] ERR_MAX    = (N_IN+1)'(VEC_CNT);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N_IN-1:0] step;
  logic [N_IN-1:0] step_nxt;
  logic [N_IN-1:0] vec_nxt;

  assign step_nxt = step + N_IN'(1);

  // Vector for the next step is registered on DRIVE entry so it is stable
  // through the whole settle and sample window.
  sweep_vec_gen #(.N_IN(N_IN)) u_vec_gen (
    .step (step_nxt),
    .vec  (vec_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      step          <= '0;
      vec_o         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tt_a          <= '0;
      tt_b          <= '0;
      mismatch      <= 1'b0;
      first_bad_idx <= '0;
      err_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= DRIVE;
            step          <= '0;
            vec_o         <= '0;
            cnt           <= CNT_RELOAD;
            busy          <= 1'b1;
            tt_a          <= '0;
            tt_b          <= '0;
            mismatch      <= 1'b0;
            first_bad_idx <= '0;
            err_cnt       <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SAMPLE: begin
          // Abort wins over capture so a cut-short sweep never records a half-settled sample.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tt_a[vec_o] <= fa_i;
            tt_b[vec_o] <= fb_i;
            if (fa_i != fb_i) begin
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + (N_IN+1)'(1);
              if (!mismatch) begin
                mismatch      <= 1'b1;
                first_bad_idx <= vec_o;
              end
            end
            if (&step) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              step  <= step_nxt;
              vec_o <= vec_nxt;
              cnt   <= CNT_RELOAD;
              state <= DRIVE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: parity models, injected faults, abort,
// restart, mid-sweep reset and a zero-settle instance.
module tb_truth_table_sweeper;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, fa, fb, busy, done, mismatch;
  logic [3:0]  vec, first_bad;
  logic [15:0] tt_a, tt_b;
  logic [4:0]  err_cnt;

  logic        start0, abort0, fa0, fb0, busy0, done0, mismatch0;
  logic [3:0]  vec0, first_bad0;
  logic [15:0] tt_a0, tt_b0;
  logic [4:0]  err_cnt0;

  logic        fa_const_en, fa_const, fb_const_en, fb_const;
  logic [15:0] flip_mask;
  logic [3:0]  seq[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec),
    .fa_i(fa), .fb_i(fb), .busy(busy), .done(done), .tt_a(tt_a), .tt_b(tt_b),
    .mismatch(mismatch), .first_bad_idx(first_bad), .err_cnt(err_cnt)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .vec_o(vec0),
    .fa_i(fa0), .fb_i(fb0), .busy(busy0), .done(done0), .tt_a(tt_a0), .tt_b(tt_b0),
    .mismatch(mismatch0), .first_bad_idx(first_bad0), .err_cnt(err_cnt0)
  );

  // Function-under-test models: 4-input parity with optional fault injection.
  always_comb begin
    fa = fa_const_en ? fa_const : ^vec;
    fb = fb_const_en ? fb_const : ((^vec) ^ flip_mask[vec]);
  end
  assign fa0 = ^vec0;
  assign fb0 = ^vec0;

  always @(negedge clk)
    if (busy && (seq.size() == 0 || vec != seq[seq.size()-1])) seq.push_back(vec);

  task automatic run_sweep(input int repulse, input bit start_in_done, output int lat);
    bit busy_lost = 0;
    lat = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_on got=%b exp=1", busy); end
    for (int k = 1; k <= 300; k++) begin
      if (k == repulse) begin
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (done === 1'b1) begin lat = k; break; end
      if (busy !== 1'b1) busy_lost = 1;
    end
    checks++; if (busy_lost) begin failures++; $display("FAIL busy_held got=dropped exp=held"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    if (start_in_done) begin
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done_ignored busy=%b exp=0", busy); end
    end
  endtask

  task automatic set_model(input logic [15:0] mask);
    fa_const_en = 0; fa_const = 0; fb_const_en = 0; fb_const = 0; flip_mask = mask;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, vec, tt_a, tt_b, mismatch, first_bad, err_cnt} !== '0) begin
      failures++; $display("FAIL reset_state got=%b/%b/%h/%h/%h/%b/%h/%h exp=all0",
                           busy, done, vec, tt_a, tt_b, mismatch, first_bad, err_cnt);
    end
    checks++;
    if ({busy0, done0, vec0, tt_a0, tt_b0, mismatch0, first_bad0, err_cnt0} !== '0) begin
      failures++; $display("FAIL reset_state0 got=nonzero exp=all0");
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_parity;
    int lat;
    logic [3:0] gray_tab [16] = '{0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8};
    int bad_order = 0;
    int bad_ham = 0;
    set_model(16'h0000);
    seq.delete();
    run_sweep(0, 0, lat);
    checks++; if (lat != 64) begin failures++; $display("FAIL parity_latency got=%0d exp=64", lat); end
    checks++; if (tt_a !== 16'h6996) begin failures++; $display("FAIL parity_tt_a got=%h exp=6996", tt_a); end
    checks++; if (tt_b !== 16'h6996) begin failures++; $display("FAIL parity_tt_b got=%h exp=6996", tt_b); end
    checks++; if ({mismatch, err_cnt} !== 6'd0) begin failures++; $display("FAIL parity_clean mm=%b err=%0d exp=0/0", mismatch, err_cnt); end
    checks++; if (seq.size() != 16) begin failures++; $display("FAIL vec_seq_len got=%0d exp=16", seq.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
`ifdef SWEEP_GRAY_EN
        if (seq[i] !== gray_tab[i]) bad_order++;
        if (i > 0 && $countones(seq[i] ^ seq[i-1]) != 1) bad_ham++;
`else
        if (seq[i] !== 4'(i)) bad_order++;
        if (i > 0 && gray_tab[i] === 4'hx) bad_ham++;
`endif
      end
      if (bad_order != 0) begin failures++; $display("FAIL vec_seq_order bad_steps=%0d exp=0", bad_order); end
`ifdef SWEEP_GRAY_EN
      checks++; if (bad_ham != 0) begin failures++; $display("FAIL vec_seq_hamming bad_steps=%0d exp=0", bad_ham); end
`endif
    end
  endtask

  task automatic test_faults;
    int lat;
    set_model(16'h0020);
    run_sweep(0, 0, lat);
    checks++; if (tt_b !== 16'h69B6) begin failures++; $display("FAIL flip5_tt_b got=%h exp=69b6", tt_b); end
    checks++; if (tt_a !== 16'h6996) begin failures++; $display("FAIL flip5_tt_a got=%h exp=6996", tt_a); end
    checks++; if ({mismatch, first_bad, err_cnt} !== {1'b1, 4'd5, 5'd1}) begin
      failures++; $display("FAIL flip5_flags mm=%b idx=%0d err=%0d exp=1/5/1", mismatch, first_bad, err_cnt); end
    set_model(16'h1020);
    run_sweep(0, 0, lat);
    checks++; if (tt_b !== 16'h79B6) begin failures++; $display("FAIL flip5_12_tt_b got=%h exp=79b6", tt_b); end
    checks++; if ({mismatch, first_bad, err_cnt} !== {1'b1, 4'd5, 5'd2}) begin
      failures++; $display("FAIL flip5_12_flags mm=%b idx=%0d err=%0d exp=1/5/2", mismatch, first_bad, err_cnt); end
  endtask

  task automatic test_const;
    int lat;
    set_model(16'h0000);
    fa_const_en = 1; fa_const = 1; fb_const_en = 1; fb_const = 0;
    run_sweep(0, 0, lat);
    checks++; if ({tt_a, tt_b} !== {16'hFFFF, 16'h0000}) begin
      failures++; $display("FAIL const_tt got=%h/%h exp=ffff/0000", tt_a, tt_b); end
    checks++; if ({mismatch, first_bad, err_cnt} !== {1'b1, 4'd0, 5'd16}) begin
      failures++; $display("FAIL const_flags mm=%b idx=%0d err=%0d exp=1/0/16", mismatch, first_bad, err_cnt); end
  endtask

  task automatic test_abort;
    int lat;
    bit seen7 = 0;
    bit done_seen = 0;
    set_model(16'h0000);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_beats_abort busy=%b exp=1", busy); end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vec === 4'd7) begin seen7 = 1; break; end
    end
    checks++; if (!seen7) begin failures++; $display("FAIL abort_wait_vec7 got=timeout exp=vec7"); end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++; if ({busy, vec} !== {1'b0, 4'd7}) begin
      failures++; $display("FAIL abort_stop busy=%b vec=%0d exp=0/7", busy, vec); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1;
    end
    checks++; if (done_seen) begin failures++; $display("FAIL abort_no_done got=activity exp=idle"); end
`ifdef SWEEP_GRAY_EN
    checks++; if ({tt_a, tt_b} !== {16'h0006, 16'h0006}) begin
      failures++; $display("FAIL abort_partial got=%h/%h exp=0006/0006", tt_a, tt_b); end
`else
    checks++; if ({tt_a, tt_b} !== {16'h0016, 16'h0016}) begin
      failures++; $display("FAIL abort_partial got=%h/%h exp=0016/0016", tt_a, tt_b); end
`endif
    run_sweep(0, 0, lat);
    checks++; if (lat != 64 || tt_a !== 16'h6996) begin
      failures++; $display("FAIL after_abort lat=%0d tt_a=%h exp=64/6996", lat, tt_a); end
  endtask

  task automatic test_back_to_back;
    int lat;
    set_model(16'h0000);
    run_sweep(20, 1, lat);
    checks++; if (lat != 64) begin failures++; $display("FAIL repulse_latency got=%0d exp=64", lat); end
    checks++; if ({tt_a, tt_b, err_cnt} !== {16'h6996, 16'h6996, 5'd0}) begin
      failures++; $display("FAIL repulse_result got=%h/%h/%0d exp=6996/6996/0", tt_a, tt_b, err_cnt); end
  endtask

  task automatic test_reset_mid;
    bit act = 0;
    set_model(16'h0020);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, vec, tt_a, tt_b, mismatch, first_bad, err_cnt} !== '0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%h/%b/%0d exp=all0", busy, vec, tt_a, mismatch, err_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) act = 1;
    end
    checks++; if (act) begin failures++; $display("FAIL reset_no_done got=activity exp=idle"); end
  endtask

  task automatic test_settle0;
    int lat = -1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != 32) begin failures++; $display("FAIL settle0_latency got=%0d exp=32", lat); end
    checks++; if ({tt_a0, tt_b0, mismatch0} !== {16'h6996, 16'h6996, 1'b0}) begin
      failures++; $display("FAIL settle0_tt got=%h/%h/%b exp=6996/6996/0", tt_a0, tt_b0, mismatch0); end
  endtask

  initial begin
    start = 0; abort = 0; start0 = 0; abort0 = 0;
    set_model(16'h0000);
    test_reset;
    test_parity;
    test_faults;
    test_const;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_settle0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
